// File: rtl/branch_resolve_tracker.sv
// rtl/branch_resolve_tracker.sv - in-order branch tag tracker with out-of-order resolve, ordered retire and redirect sequencing
module branch_resolve_tracker #(
  parameter int NR_ENTRIES = 4,
  parameter int VLEN = 64,
  localparam int TAG_W = $clog2(NR_ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             alloc_valid_i,
  input  logic [VLEN-1:0]  alloc_pc_i,
  output logic             alloc_ready_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             resolve_valid_i,
  input  logic [TAG_W-1:0] resolve_tag_i,
  input  logic             resolve_mispredict_i,
  input  logic [VLEN-1:0]  resolve_target_i,
  output logic             resolve_err_o,
  output logic             redirect_valid_o,
  output logic [VLEN-1:0]  redirect_pc_o,
  input  logic             redirect_ack_i,
  output logic             retire_valid_o,
  output logic [VLEN-1:0]  retire_pc_o,
  output logic [TAG_W:0]   count_o
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(NR_ENTRIES);

  typedef enum logic [0:0] {IDLE, FLUSH} state_t;

  state_t state_q, state_d;

  logic [NR_ENTRIES-1:0] valid_q, resolved_q, mispredict_q;
  logic [VLEN-1:0]       pc_q     [NR_ENTRIES];
  logic [VLEN-1:0]       target_q [NR_ENTRIES];
  logic [TAG_W-1:0]      head_q, tail_q;
  logic [TAG_W:0]        count_q;

  logic            retire_valid_q, resolve_err_q;
  logic [VLEN-1:0] retire_pc_q, redirect_pc_q;

  logic alloc_fire, retire_fire, enter_flush, clear_all;
  logic resolve_hit_bad, resolve_ok, resolve_bad;
  logic head_ready;

  // The head may leave the buffer only once its resolution has been stored.
  assign head_ready      = valid_q[head_q] && resolved_q[head_q];
  assign alloc_ready_o   = (state_q == IDLE) && (count_q != FULL_CNT) && !flush_i;
  assign alloc_tag_o     = tail_q;
  assign alloc_fire      = alloc_valid_i && alloc_ready_o;
  assign resolve_hit_bad = !valid_q[resolve_tag_i] || resolved_q[resolve_tag_i];
  assign resolve_ok      = resolve_valid_i && !flush_i && !resolve_hit_bad;
  assign resolve_bad     = resolve_valid_i && !flush_i && resolve_hit_bad;

  assign redirect_valid_o = (state_q == FLUSH);
  assign redirect_pc_o    = redirect_pc_q;
  assign retire_valid_o   = retire_valid_q;
  assign retire_pc_o      = retire_pc_q;
  assign resolve_err_o    = resolve_err_q;
  assign count_o          = count_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: external flush wins, otherwise retire or start a redirect from the head.
  always_comb begin
    state_d     = state_q;
    retire_fire = 1'b0;
    enter_flush = 1'b0;
    clear_all   = 1'b0;
    if (flush_i) begin
      state_d   = IDLE;
      clear_all = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (head_ready) begin
            if (mispredict_q[head_q]) begin
              state_d     = FLUSH;
              enter_flush = 1'b1;
            end else begin
              retire_fire = 1'b1;
            end
          end
        end
        FLUSH: begin
          if (redirect_ack_i) begin
            state_d   = IDLE;
            clear_all = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Entry storage; alloc, resolve and retire always touch disjoint entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= '0;
      resolved_q   <= '0;
      mispredict_q <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        pc_q[i]     <= '0;
        target_q[i] <= '0;
      end
    end else if (clear_all) begin
      valid_q      <= '0;
      resolved_q   <= '0;
      mispredict_q <= '0;
    end else begin
      if (alloc_fire) begin
        valid_q[tail_q]    <= 1'b1;
        resolved_q[tail_q] <= 1'b0;
        pc_q[tail_q]       <= alloc_pc_i;
      end
      if (resolve_ok) begin
        resolved_q[resolve_tag_i]   <= 1'b1;
        mispredict_q[resolve_tag_i] <= resolve_mispredict_i;
        target_q[resolve_tag_i]     <= resolve_target_i;
      end
      if (retire_fire) begin
        valid_q[head_q]    <= 1'b0;
        resolved_q[head_q] <= 1'b0;
      end
    end
  end

  // Head/tail pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear_all) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc_fire)  tail_q <= tail_q + TAG_W'(1);
      if (retire_fire) head_q <= head_q + TAG_W'(1);
      count_q <= count_q + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, retire_fire};
    end
  end

  // Registered retire/error pulses and the latched redirect target.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_valid_q <= 1'b0;
      retire_pc_q    <= '0;
      resolve_err_q  <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      retire_valid_q <= retire_fire;
      resolve_err_q  <= resolve_bad;
      if (retire_fire) retire_pc_q <= pc_q[head_q];
      if (clear_all)        redirect_pc_q <= '0;
      else if (enter_flush) redirect_pc_q <= target_q[head_q];
    end
  end

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// tb/tb_branch_resolve_tracker.sv - directed table-driven bench for branch_resolve_tracker
module tb_branch_resolve_tracker;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        alloc_valid_i;
  logic [63:0] alloc_pc_i;
  logic        alloc_ready_o;
  logic [1:0]  alloc_tag_o;
  logic        resolve_valid_i;
  logic [1:0]  resolve_tag_i;
  logic        resolve_mispredict_i;
  logic [63:0] resolve_target_i;
  logic        resolve_err_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        redirect_ack_i;
  logic        retire_valid_o;
  logic [63:0] retire_pc_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  branch_resolve_tracker #(.NR_ENTRIES(4), .VLEN(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_pc_i(alloc_pc_i),
    .alloc_ready_o(alloc_ready_o), .alloc_tag_o(alloc_tag_o),
    .resolve_valid_i(resolve_valid_i), .resolve_tag_i(resolve_tag_i),
    .resolve_mispredict_i(resolve_mispredict_i), .resolve_target_i(resolve_target_i),
    .resolve_err_o(resolve_err_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .redirect_ack_i(redirect_ack_i),
    .retire_valid_o(retire_valid_o), .retire_pc_o(retire_pc_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // One row per cycle: inputs driven for the cycle, outputs expected during it.
  typedef struct {
    logic        fl, av;
    logic [63:0] apc;
    logic        rv;
    logic [1:0]  rt;
    logic        rm;
    logic [63:0] tg;
    logic        ack;
    logic        rdy;
    logic [1:0]  tag;
    logic        err, rdv;
    logic [63:0] rdpc;
    logic        retv;
    logic [63:0] retpc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic fl, av, input logic [63:0] apc, input logic rv,
                             input logic [1:0] rt, input logic rm, input logic [63:0] tg,
                             input logic ack, input logic rdy, input logic [1:0] tag,
                             input logic err, rdv, input logic [63:0] rdpc, input logic retv,
                             input logic [63:0] retpc, input logic [2:0] cnt);
    vec_t r;
    r.fl = fl; r.av = av; r.apc = apc; r.rv = rv; r.rt = rt; r.rm = rm; r.tg = tg; r.ack = ack;
    r.rdy = rdy; r.tag = tag; r.err = err; r.rdv = rdv; r.rdpc = rdpc;
    r.retv = retv; r.retpc = retpc; r.cnt = cnt;
    return r;
  endfunction

  task automatic drive_idle();
    flush_i = 0; alloc_valid_i = 0; alloc_pc_i = '0; resolve_valid_i = 0;
    resolve_tag_i = '0; resolve_mispredict_i = 0; resolve_target_i = '0; redirect_ack_i = 0;
  endtask

  task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    bit ok;
    int waited;
    //                 fl av apc     rv rt rm tg       ack rdy tag err rdv rdpc     retv retpc   cnt
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 0, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 1, 'h100,  0, 0, 0, 'h0,    0,  1, 0, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 1, 'h104,  0, 0, 0, 'h0,    0,  1, 1, 0, 0, 'h0,    0, 'h0,   1));
    vecs.push_back(v(0, 1, 'h108,  0, 0, 0, 'h0,    0,  1, 2, 0, 0, 'h0,    0, 'h0,   2));
    vecs.push_back(v(0, 1, 'h10C,  0, 0, 0, 'h0,    0,  1, 3, 0, 0, 'h0,    0, 'h0,   3));
    vecs.push_back(v(0, 1, 'hDEAD, 0, 0, 0, 'h0,    0,  0, 0, 0, 0, 'h0,    0, 'h0,   4));
    vecs.push_back(v(0, 0, 'h0,    1, 0, 0, 'h0,    0,  0, 0, 0, 0, 'h0,    0, 'h0,   4));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  0, 0, 0, 0, 'h0,    0, 'h0,   4));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 0, 0, 0, 'h0,    1, 'h100, 3));
    vecs.push_back(v(0, 1, 'h110,  0, 0, 0, 'h0,    0,  1, 0, 0, 0, 'h0,    0, 'h0,   3));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  0, 1, 0, 0, 'h0,    0, 'h0,   4));
    vecs.push_back(v(1, 1, 'h999,  1, 1, 0, 'h0,    0,  0, 1, 0, 0, 'h0,    0, 'h0,   4));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 0, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 1, 'h200,  0, 0, 0, 'h0,    0,  1, 0, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 1, 'h204,  0, 0, 0, 'h0,    0,  1, 1, 0, 0, 'h0,    0, 'h0,   1));
    vecs.push_back(v(0, 1, 'h208,  0, 0, 0, 'h0,    0,  1, 2, 0, 0, 'h0,    0, 'h0,   2));
    vecs.push_back(v(0, 0, 'h0,    1, 2, 0, 'h0,    0,  1, 3, 0, 0, 'h0,    0, 'h0,   3));
    vecs.push_back(v(0, 0, 'h0,    1, 1, 0, 'h0,    0,  1, 3, 0, 0, 'h0,    0, 'h0,   3));
    vecs.push_back(v(0, 0, 'h0,    1, 0, 0, 'h0,    0,  1, 3, 0, 0, 'h0,    0, 'h0,   3));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 3, 0, 0, 'h0,    0, 'h0,   3));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 3, 0, 0, 'h0,    1, 'h200, 2));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 3, 0, 0, 'h0,    1, 'h204, 1));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 3, 0, 0, 'h0,    1, 'h208, 0));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 3, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(1, 0, 'h0,    0, 0, 0, 'h0,    0,  0, 3, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 0, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 1, 'h300,  0, 0, 0, 'h0,    0,  1, 0, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 1, 'h304,  0, 0, 0, 'h0,    0,  1, 1, 0, 0, 'h0,    0, 'h0,   1));
    vecs.push_back(v(0, 0, 'h0,    1, 0, 1, 'h2000, 0,  1, 2, 0, 0, 'h0,    0, 'h0,   2));
    vecs.push_back(v(0, 1, 'h308,  0, 0, 0, 'h0,    0,  1, 2, 0, 0, 'h0,    0, 'h0,   2));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  0, 3, 0, 1, 'h2000, 0, 'h0,   3));
    vecs.push_back(v(0, 0, 'h0,    1, 1, 0, 'h0,    0,  0, 3, 0, 1, 'h2000, 0, 'h0,   3));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  0, 3, 0, 1, 'h2000, 0, 'h0,   3));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    1,  0, 3, 0, 1, 'h2000, 0, 'h0,   3));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 0, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 0, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 0, 'h0,    1, 2, 0, 'h0,    0,  1, 0, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 0, 1, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 0, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 1, 'h400,  0, 0, 0, 'h0,    0,  1, 0, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 0, 'h0,    1, 0, 0, 'h0,    0,  1, 1, 0, 0, 'h0,    0, 'h0,   1));
    vecs.push_back(v(0, 0, 'h0,    1, 0, 0, 'h0,    0,  1, 1, 0, 0, 'h0,    0, 'h0,   1));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 1, 1, 0, 'h0,    1, 'h400, 0));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 1, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 1, 'h500,  0, 0, 0, 'h0,    0,  1, 1, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 0, 'h0,    1, 1, 1, 'h3000, 0,  1, 2, 0, 0, 'h0,    0, 'h0,   1));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 2, 0, 0, 'h0,    0, 'h0,   1));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  0, 2, 0, 1, 'h3000, 0, 'h0,   1));
    vecs.push_back(v(1, 0, 'h0,    0, 0, 0, 'h0,    0,  0, 2, 0, 1, 'h3000, 0, 'h0,   1));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    1,  1, 0, 0, 0, 'h0,    0, 'h0,   0));
    vecs.push_back(v(0, 0, 'h0,    0, 0, 0, 'h0,    0,  1, 0, 0, 0, 'h0,    0, 'h0,   0));

    drive_idle();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      flush_i = vecs[i].fl; alloc_valid_i = vecs[i].av; alloc_pc_i = vecs[i].apc;
      resolve_valid_i = vecs[i].rv; resolve_tag_i = vecs[i].rt;
      resolve_mispredict_i = vecs[i].rm; resolve_target_i = vecs[i].tg;
      redirect_ack_i = vecs[i].ack;
      #1;
      ok = (alloc_ready_o === vecs[i].rdy) && (alloc_tag_o === vecs[i].tag) &&
           (resolve_err_o === vecs[i].err) && (redirect_valid_o === vecs[i].rdv) &&
           (!vecs[i].rdv || redirect_pc_o === vecs[i].rdpc) &&
           (retire_valid_o === vecs[i].retv) &&
           (!vecs[i].retv || retire_pc_o === vecs[i].retpc) && (count_o === vecs[i].cnt);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL row %0d: got rdy=%0b tag=%0d err=%0b rdv=%0b rdpc=%0h retv=%0b retpc=%0h cnt=%0d expected rdy=%0b tag=%0d err=%0b rdv=%0b rdpc=%0h retv=%0b retpc=%0h cnt=%0d",
                 i, alloc_ready_o, alloc_tag_o, resolve_err_o, redirect_valid_o, redirect_pc_o,
                 retire_valid_o, retire_pc_o, count_o, vecs[i].rdy, vecs[i].tag, vecs[i].err,
                 vecs[i].rdv, vecs[i].rdpc, vecs[i].retv, vecs[i].retpc, vecs[i].cnt);
      end
    end

    // Asynchronous reset while a redirect is pending, with no clock edge in between.
    @(negedge clk_i);
    drive_idle();
    alloc_valid_i = 1; alloc_pc_i = 'h600;
    @(negedge clk_i);
    drive_idle();
    resolve_valid_i = 1; resolve_tag_i = 0; resolve_mispredict_i = 1; resolve_target_i = 'h4000;
    @(negedge clk_i);
    drive_idle();
    waited = 0;
    while (!redirect_valid_o && waited < 10) begin
      @(negedge clk_i);
      waited++;
    end
    #1;
    check1("mid_flush_redirect_valid", 64'(redirect_valid_o), 64'd1);
    check1("mid_flush_redirect_pc", redirect_pc_o, 64'h4000);
    check1("mid_flush_count", 64'(count_o), 64'd1);
    check1("mid_flush_alloc_ready", 64'(alloc_ready_o), 64'd0);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check1("async_rst_redirect_valid", 64'(redirect_valid_o), 64'd0);
    check1("async_rst_redirect_pc", redirect_pc_o, 64'h0);
    check1("async_rst_count", 64'(count_o), 64'd0);
    check1("async_rst_alloc_ready", 64'(alloc_ready_o), 64'd1);
    check1("async_rst_alloc_tag", 64'(alloc_tag_o), 64'd0);
    check1("async_rst_retire_valid", 64'(retire_valid_o), 64'd0);
    check1("async_rst_resolve_err", 64'(resolve_err_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    check1("post_rst_redirect_valid", 64'(redirect_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_tracker.md
Name: branch_resolve_tracker

Overview:
- In-order tracker for speculative control-flow instructions between issue and the branch unit.
- Allocates a tag per in-flight branch/jump and records out-of-order resolutions.
- Retires entries oldest-first and sequences the front-end flush/redirect handshake when the oldest unretired entry was mispredicted.
- Sits beside the branch unit; driven by the issue stage and the branch unit's resolved-branch output.

Parameters:
NR_ENTRIES, 4, tracker depth; power of two, minimum 2
VLEN, 64, virtual address width
TAG_W, $clog2(NR_ENTRIES), tag width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  external flush (exception/commit); highest priority
alloc_valid_i  in  1  issue requests an entry for a control-flow instruction
alloc_pc_i  in  VLEN  PC of that instruction
alloc_ready_o  out  1  entry available
alloc_tag_o  out  TAG_W  tag granted (valid when alloc_valid_i && alloc_ready_o)
resolve_valid_i  in  1  branch unit resolved an instruction
resolve_tag_i  in  TAG_W  tag being resolved
resolve_mispredict_i  in  1  resolution was a mispredict
resolve_target_i  in  VLEN  correct next PC
resolve_err_o  out  1  one-cycle pulse: resolution to a free or already-resolved tag
redirect_valid_o  out  1  front-end flush/redirect request
redirect_pc_o  out  VLEN  redirect target
redirect_ack_i  in  1  front end accepted the redirect
retire_valid_o  out  1  one-cycle pulse: head entry retired correctly predicted
retire_pc_o  out  VLEN  PC of the retired entry
count_o  out  TAG_W+1  occupied entries

Behaviour:
- Storage: circular buffer of NR_ENTRIES entries {valid, resolved, mispredict, pc, target}; head/tail pointers of TAG_W bits wrap modulo NR_ENTRIES; count register of TAG_W+1 bits.
- Reset: all entries invalid; head = tail = count = 0; state IDLE. All outputs 0, except alloc_ready_o = 1.
- Allocation:
  - alloc_ready_o = (state == IDLE) && (count < NR_ENTRIES) && !flush_i. It never depends on a same-cycle retire.
  - alloc_tag_o = tail, combinational.
  - On handshake, the entry at tail is written valid=1, resolved=0, pc=alloc_pc_i; tail increments.
- Resolution:
  - On resolve_valid_i, the entry at resolve_tag_i gets resolved=1 and mispredict/target are stored; visible next cycle.
  - If that entry is invalid or already resolved, the write is dropped and resolve_err_o pulses the next cycle.
  - Resolution is accepted in IDLE and FLUSH. In FLUSH it has no effect beyond storage.
- States:
  - IDLE:
    - If head.valid && head.resolved && !head.mispredict: pulse retire_valid_o with retire_pc_o = head.pc, invalidate head, increment head. At most one retire per cycle.
    - If head.valid && head.resolved && head.mispredict: go to FLUSH; redirect_pc_o is latched from head.target.
  - FLUSH:
    - redirect_valid_o = 1 and redirect_pc_o stays stable until redirect_ack_i.
    - On ack, invalidate all entries, set head = tail = count = 0, return to IDLE. redirect_valid_o is low the cycle after ack.
    - Younger entries are never retired while in FLUSH.
- count_o: +1 on alloc, -1 on retire, both same cycle leaves it unchanged; cleared on flush/ack.
- Simultaneous events in one cycle:
  - Alloc + retire both take effect.
  - Alloc + head-mispredict detection: the alloc proceeds, because ready was computed in IDLE, and the new entry is discarded by the flush.
  - Resolution of the head tag only takes effect for retire/flush the next cycle (1-cycle latency from resolve to retire or redirect).
- flush_i, any state: next cycle all entries are invalid, pointers and count are 0, state is IDLE, redirect_valid_o = 0. Same-cycle alloc and resolve are ignored, and no retire pulse is generated.
- Reset asserted mid-FLUSH: immediate return to reset values; no ack is required.
- Full: count == NR_ENTRIES holds alloc_ready_o low. Pointer wrap-around is legal and is not an error.

Test Plan:
- Reset, 4 allocs with PCs 0x100, 0x104, 0x108, 0x10C -> tags 0,1,2,3; count_o=4; alloc_ready_o=0. Resolve tag 0 correct -> retire_valid_o with retire_pc_o=0x100 two cycles after the resolve; alloc_ready_o=1; the next alloc gets tag 0 (wrap).
- Out-of-order resolve: alloc 3 entries, resolve tags 2, 1, 0 all correct -> retire pulses occur only after tag 0 resolves, in order 0,1,2 on consecutive cycles; count_o reaches 0.
- Mispredict: alloc tags 0,1, resolve tag 0 mispredict with target 0x2000 -> redirect_valid_o=1 and redirect_pc_o=0x2000 hold for 3 cycles without ack; alloc_ready_o=0. Ack -> count_o=0, state IDLE, and tag 1 is never retired.
- Invalid resolve: resolve tag 2 when empty -> resolve_err_o pulses once; no state change. Double resolve of tag 0 -> the second pulses resolve_err_o.
- flush_i during FLUSH with the redirect pending -> next cycle redirect_valid_o=0, count_o=0, alloc_ready_o=1; a later redirect_ack_i is ignored.
- Async reset asserted mid-FLUSH, without a clock edge -> outputs go to reset values immediately.
